// File: rtl/pc_next_unit.sv
// Registered, stall-aware next-PC unit: PC+4, branch, J-type and JR targets.
// Optional misaligned-JR trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_next_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_ready,
    input  logic              halt,
    input  logic              br_taken,
    input  logic [15:0]       br_offset,
    input  logic              jmp,
    input  logic [25:0]       jmp_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] pc_plus4,
`ifdef PC_MISALIGN_TRAP_EN
    output logic              misalign_trap,
    output logic [ADDR_W-1:0] bad_pc,
`endif
    output logic              redirect_taken
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } state_e;

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_valid_q;
    logic              redirect_q;

    logic [ADDR_W-1:0] pc_plus4_c;
    logic [ADDR_W-1:0] br_disp_c;
    logic [ADDR_W-1:0] br_target_c;
    logic [3:0]        p4_top_c;
    logic [ADDR_W-1:0] jmp_target_c;
    logic [ADDR_W-1:0] jr_target_c;
    logic [ADDR_W-1:0] redir_target_c;
    logic              redirect_c;
    logic              advance_c;
    logic              issuing_c;

    // Target arithmetic, all modulo 2^ADDR_W.
    assign pc_plus4_c   = pc_q + ADDR_W'(4);
    assign br_disp_c    = ADDR_W'({{14{br_offset[15]}}, br_offset, 2'b00});
    assign br_target_c  = pc_plus4_c + br_disp_c;
    assign p4_top_c     = 4'(32'(pc_plus4_c) >> 28);
    assign jmp_target_c = ADDR_W'({p4_top_c, jmp_index, 2'b00});

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [ADDR_W-1:0] EXC_VECTOR_W = ADDR_W'(EXC_VECTOR);

    logic              misalign_c;
    logic              trap_q;
    logic [ADDR_W-1:0] bad_pc_q;

    assign misalign_c  = |jr_target[1:0];
    assign jr_target_c = misalign_c ? EXC_VECTOR_W : {jr_target[ADDR_W-1:2], 2'b00};
`else
    logic unused_cfg;

    assign jr_target_c = {jr_target[ADDR_W-1:2], 2'b00};
    assign unused_cfg  = ^{jr_target[1:0], EXC_VECTOR};
`endif

    // Halt wins over redirects and advance on the edge it is sampled in RUN.
    always_comb begin
        issuing_c      = 1'b0;
        redirect_c     = 1'b0;
        advance_c      = 1'b0;
        redir_target_c = br_target_c;
        if (state_q == ST_RUN && !halt) begin
            issuing_c = 1'b1;
        end
        if (issuing_c) begin
            redirect_c = jr | jmp | br_taken;
            advance_c  = fetch_ready & ~(jr | jmp | br_taken);
        end
        if (jr) begin
            redir_target_c = jr_target_c;
        end else if (jmp) begin
            redir_target_c = jmp_target_c;
        end
    end

    // Control state, PC register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC_W;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
            bad_pc_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_RUN;
                    pc_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    if (halt) begin
                        state_q    <= ST_HALTED;
                        pc_valid_q <= 1'b0;
                    end else begin
                        pc_valid_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!halt) begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_BOOT;
                    pc_valid_q <= 1'b0;
                end
            endcase

            if (redirect_c) begin
                pc_q <= redir_target_c;
            end else if (advance_c) begin
                pc_q <= pc_plus4_c;
            end
            redirect_q <= redirect_c;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q <= redirect_c & jr & misalign_c;
            if (redirect_c && jr && misalign_c) begin
                bad_pc_q <= jr_target;
            end
`endif
        end
    end

    assign pc             = pc_q;
    assign pc_valid       = pc_valid_q;
    assign pc_plus4       = pc_plus4_c;
    assign redirect_taken = redirect_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_trap  = trap_q;
    assign bad_pc         = bad_pc_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: a 32-bit instance and a 16-bit instance.
module tb_pc_next_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst16_n;

    logic        fetch_ready, halt, br_taken, jmp, jr;
    logic [15:0] br_offset;
    logic [25:0] jmp_index;
    logic [31:0] jr_target;
    logic [31:0] pc, pc_plus4;
    logic        pc_valid, redirect_taken;

    logic        s_fetch_ready, s_halt, s_br_taken, s_jmp, s_jr;
    logic [15:0] s_br_offset;
    logic [25:0] s_jmp_index;
    logic [15:0] s_jr_target;
    logic [15:0] s_pc, s_pc_plus4;
    logic        s_pc_valid, s_redirect_taken;

`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_trap, s_misalign_trap;
    logic [31:0] bad_pc;
    logic [15:0] s_bad_pc;
`endif

    pc_next_unit #(.ADDR_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .halt(halt),
        .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp), .jmp_index(jmp_index),
        .jr(jr), .jr_target(jr_target), .pc(pc), .pc_valid(pc_valid), .pc_plus4(pc_plus4),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_trap(misalign_trap), .bad_pc(bad_pc),
`endif
        .redirect_taken(redirect_taken)
    );

    pc_next_unit #(.ADDR_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst16_n), .fetch_ready(s_fetch_ready), .halt(s_halt),
        .br_taken(s_br_taken), .br_offset(s_br_offset), .jmp(s_jmp), .jmp_index(s_jmp_index),
        .jr(s_jr), .jr_target(s_jr_target), .pc(s_pc), .pc_valid(s_pc_valid), .pc_plus4(s_pc_plus4),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_trap(s_misalign_trap), .bad_pc(s_bad_pc),
`endif
        .redirect_taken(s_redirect_taken)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] p4;
        logic        v;
        logic        rt;
        logic        trap;
        logic [31:0] bad;
    } exp_t;

    exp_t  q32[$];
    exp_t  q16[$];
    string n32[$];
    string n16[$];

    int          checks = 0;
    int          errors = 0;
    logic        exp_trap = 1'b0;
    logic [31:0] exp_bad  = 32'h0;

    exp_t  e32, e16;
    string nm32, nm16;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, exp);
        end
    endtask

    task automatic push32(input string nm, input logic [31:0] p, input logic v, input logic rt);
        exp_t e;
        e.pc = p; e.p4 = p + 32'd4; e.v = v; e.rt = rt; e.trap = exp_trap; e.bad = exp_bad;
        q32.push_back(e);
        n32.push_back(nm);
    endtask

    task automatic tick32(input string nm, input logic [31:0] p, input logic v, input logic rt);
        @(posedge clk);
        #1;
        push32(nm, p, v, rt);
    endtask

    task automatic push16(input string nm, input logic [15:0] p, input logic v, input logic rt);
        exp_t e;
        logic [15:0] p4;
        p4 = p + 16'd4;
        e.pc = 32'(p); e.p4 = 32'(p4); e.v = v; e.rt = rt; e.trap = 1'b0; e.bad = 32'h0;
        q16.push_back(e);
        n16.push_back(nm);
    endtask

    task automatic tick16(input string nm, input logic [15:0] p, input logic v, input logic rt);
        @(posedge clk);
        #1;
        push16(nm, p, v, rt);
    endtask

    // Monitor: one expectation per queue per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q32.size() != 0) begin
            e32  = q32.pop_front();
            nm32 = n32.pop_front();
            chk(nm32, "pc", pc, e32.pc);
            chk(nm32, "pc_plus4", pc_plus4, e32.p4);
            chk(nm32, "pc_valid", 32'(pc_valid), 32'(e32.v));
            chk(nm32, "redirect_taken", 32'(redirect_taken), 32'(e32.rt));
`ifdef PC_MISALIGN_TRAP_EN
            chk(nm32, "misalign_trap", 32'(misalign_trap), 32'(e32.trap));
            chk(nm32, "bad_pc", bad_pc, e32.bad);
`endif
        end
        if (q16.size() != 0) begin
            e16  = q16.pop_front();
            nm16 = n16.pop_front();
            chk(nm16, "pc", 32'(s_pc), e16.pc);
            chk(nm16, "pc_plus4", 32'(s_pc_plus4), e16.p4);
            chk(nm16, "pc_valid", 32'(s_pc_valid), 32'(e16.v));
            chk(nm16, "redirect_taken", 32'(s_redirect_taken), 32'(e16.rt));
`ifdef PC_MISALIGN_TRAP_EN
            chk(nm16, "misalign_trap", 32'(s_misalign_trap), 32'(e16.trap));
            chk(nm16, "bad_pc", 32'(s_bad_pc), e16.bad);
`endif
        end
    end

    initial begin
        rst_n = 1'b0; rst16_n = 1'b0;
        fetch_ready = 1'b1; halt = 1'b0; br_taken = 1'b0; br_offset = 16'h0;
        jmp = 1'b0; jmp_index = 26'h0; jr = 1'b0; jr_target = 32'h0;
        s_fetch_ready = 1'b1; s_halt = 1'b0; s_br_taken = 1'b0; s_br_offset = 16'h0;
        s_jmp = 1'b0; s_jmp_index = 26'h0; s_jr = 1'b0; s_jr_target = 16'h0;

        // Reset and boot
        tick32("reset", 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        push32("boot_idle", 32'h0, 1'b0, 1'b0);
        tick32("run_pc0", 32'h0, 1'b1, 1'b0);
        tick32("run_pc4", 32'h4, 1'b1, 1'b0);
        tick32("run_pc8", 32'h8, 1'b1, 1'b0);

        // Backward branch from 0x40
        jr = 1'b1; jr_target = 32'h40;
        tick32("jr_to_40", 32'h40, 1'b1, 1'b1);
        jr = 1'b0; br_taken = 1'b1; br_offset = 16'hFFFC;
        tick32("br_back", 32'h34, 1'b1, 1'b1);
        br_taken = 1'b0;
        tick32("after_br", 32'h38, 1'b1, 1'b0);

        // Priority: jr > jmp > br
        jr = 1'b1; jmp = 1'b1; br_taken = 1'b1;
        jr_target = 32'h200; jmp_index = 26'h5; br_offset = 16'h0004;
        tick32("prio_jr", 32'h200, 1'b1, 1'b1);
        jr = 1'b0;
        tick32("prio_jmp", 32'h14, 1'b1, 1'b1);
        jmp = 1'b0; br_taken = 1'b0;
        jr = 1'b1; jr_target = 32'h1000_0000;
        tick32("jr_hi", 32'h1000_0000, 1'b1, 1'b1);
        jr = 1'b0; jmp = 1'b1; jmp_index = 26'h0000010;
        tick32("jmp_region", 32'h1000_0040, 1'b1, 1'b1);
        jmp = 1'b0;

        // Stall holds; redirect still applies during stall
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick32("stall_hold", 32'h1000_0040, 1'b1, 1'b0);
        br_taken = 1'b1; br_offset = 16'h0004;
        tick32("stall_br", 32'h1000_0054, 1'b1, 1'b1);
        br_taken = 1'b0;
        tick32("stall_after_br", 32'h1000_0054, 1'b1, 1'b0);
        fetch_ready = 1'b1;
        tick32("seq_resume", 32'h1000_0058, 1'b1, 1'b0);

        // Halt freezes PC and drops redirects
        halt = 1'b1;
        tick32("halt_enter", 32'h1000_0058, 1'b0, 1'b0);
        jmp = 1'b1; jmp_index = 26'h3;
        tick32("halt_jmp_dropped", 32'h1000_0058, 1'b0, 1'b0);
        jmp = 1'b0; halt = 1'b0;
        tick32("halt_exit", 32'h1000_0058, 1'b1, 1'b0);
        tick32("halt_resume", 32'h1000_005C, 1'b1, 1'b0);

        // Misaligned JR target
        jr = 1'b1; jr_target = 32'h102;
`ifdef PC_MISALIGN_TRAP_EN
        exp_trap = 1'b1; exp_bad = 32'h102;
        tick32("jr_misalign", 32'h180, 1'b1, 1'b1);
`else
        tick32("jr_misalign", 32'h100, 1'b1, 1'b1);
`endif
        jr = 1'b0; exp_trap = 1'b0;

        // Async reset while HALTED
        halt = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        tick32("halt_pre_rst", 32'h180, 1'b0, 1'b0);
`else
        tick32("halt_pre_rst", 32'h100, 1'b0, 1'b0);
`endif
        @(posedge clk); #1; rst_n = 1'b0; exp_bad = 32'h0;
        push32("async_rst", 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1; halt = 1'b0;
        push32("reboot_idle", 32'h0, 1'b0, 1'b0);
        tick32("reboot_run", 32'h0, 1'b1, 1'b0);

        // 16-bit instance: wrap and halt
        @(posedge clk); #1; rst16_n = 1'b1;
        push16("w_boot", 16'h0, 1'b0, 1'b0);
        tick16("w_run", 16'h0, 1'b1, 1'b0);
        s_jr = 1'b1; s_jr_target = 16'hFFFC;
        tick16("w_jr_fffc", 16'hFFFC, 1'b1, 1'b1);
        s_jr = 1'b0;
        tick16("w_wrap", 16'h0000, 1'b1, 1'b0);
        s_halt = 1'b1;
        tick16("w_halt", 16'h0000, 1'b0, 1'b0);
        s_jmp = 1'b1; s_jmp_index = 26'h3FF_FFFF;
        tick16("w_halt_jmp_dropped", 16'h0000, 1'b0, 1'b0);
        s_jmp = 1'b0; s_halt = 1'b0;
        tick16("w_unhalt", 16'h0000, 1'b1, 1'b0);
        tick16("w_resume", 16'h0004, 1'b1, 1'b0);
        s_jmp = 1'b1;
        tick16("w_jmp_trunc", 16'hFFFC, 1'b1, 1'b1);
        s_jmp = 1'b0;
        tick16("w_wrap2", 16'h0000, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (q32.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", q32.size(), q16.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
